// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the SR latch write driver.
// Holds the controller state encoding and the pulse/settle counter sizing.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam int MAX_CYCLES = 255;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

endpackage

// File: rtl/sr_latch_driver_if.sv
// Write-request channel into the SR latch driver.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// the master holds req_valid/req_data/req_mask until that edge, the slave may drop
// req_ready at any time and never depends on req_valid to raise it.
interface sr_latch_driver_if #(
    parameter int WIDTH = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [WIDTH-1:0] req_mask;

    modport master (
        output req_valid,
        output req_data,
        output req_mask,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_mask,
        output req_ready
    );
endinterface

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the pulse and settle phases.
// expired is high while the count sits at zero.
module sr_pulse_timer
    import sr_drv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Write-side controller for a bank of clocked SR cells: encodes masked writes into
// set/reset pulses, waits for the cells to settle, then reads back and shadows them.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int PULSE_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 1,
    parameter int SKIP_UNCHANGED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sr_latch_driver_if.slave  req,
    output logic [WIDTH-1:0]  s_out,
    output logic [WIDTH-1:0]  r_out,
    input  logic [WIDTH-1:0]  q_in,
    output logic              done,
    output logic              err,
    output logic [WIDTH-1:0]  err_bits,
    output logic [WIDTH-1:0]  shadow,
    output state_t            state_dbg
);

    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_out_q, s_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic [WIDTH-1:0] expect_q, expect_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;

    logic [WIDTH-1:0] eff;
    logic [WIDTH-1:0] set_vec;
    logic [WIDTH-1:0] rst_vec;
    logic [WIDTH-1:0] mis;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expired;

    // set_vec and rst_vec are disjoint by construction, so S=R=1 can never be driven.
    assign eff     = req.req_mask & ((SKIP_UNCHANGED != 0) ? (req.req_data ^ shadow_q) : {WIDTH{1'b1}});
    assign set_vec = eff & req.req_data;
    assign rst_vec = eff & ~req.req_data;
    assign mis     = (q_in ^ expect_q) & mask_q;

    always_comb begin
        state_d    = state_q;
        s_out_d    = s_out_q;
        r_out_d    = r_out_q;
        expect_d   = expect_q;
        mask_d     = mask_q;
        err_bits_d = err_bits_q;
        shadow_d   = shadow_q;
        done       = 1'b0;
        err        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    expect_d = req.req_data;
                    mask_d   = req.req_mask;
                    if (eff == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DRIVE;
                        s_out_d = set_vec;
                        r_out_d = rst_vec;
                    end
                end
            end
            DRIVE: begin
                if (tmr_expired) begin
                    s_out_d = '0;
                    r_out_d = '0;
                    state_d = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
                end
            end
            SETTLE: begin
                if (tmr_expired) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                done       = 1'b1;
                err        = |mis;
                err_bits_d = mis;
                shadow_d   = q_in;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The timer is reloaded on every state entry with the length of the new phase.
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        if (state_d == DRIVE) begin
            tmr_val = PULSE_LOAD;
        end else if (state_d == SETTLE) begin
            tmr_val = SETTLE_LOAD;
        end
    end

    sr_pulse_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s_out_q    <= '0;
            r_out_q    <= '0;
            expect_q   <= '0;
            mask_q     <= '0;
            err_bits_q <= '0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            s_out_q    <= s_out_d;
            r_out_q    <= r_out_d;
            expect_q   <= expect_d;
            mask_q     <= mask_d;
            err_bits_q <= err_bits_d;
            shadow_q   <= shadow_d;
        end
    end

    assign req.req_ready = (state_q == IDLE);
    assign s_out         = s_out_q;
    assign r_out         = r_out_q;
    assign err_bits      = (state_q == CHECK) ? mis : err_bits_q;
    assign shadow        = shadow_q;
    assign state_dbg     = state_q;

endmodule
